memory_access_unit: RTL and testbench

MEMORY_ACCESS_UNIT -- requirements
Module: memory_access_unit

---
 rtl/mau_pkg.sv | 17 +
 rtl/mau_lane.sv | 21 ++
 rtl/memory_access_unit.sv | 117 +++++++++++
 tb/tb_memory_access_unit.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mau_pkg.sv
// mau_pkg: shared states, funct3 codes, default memory size and lane shift helper for memory_access_unit.
package mau_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, RMW_READ, WRITE, DONE} state_e;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;
  localparam logic [2:0] F3_XX = 3'b111;
  localparam int MEM_BYTES_DEF = 2048;
  // Bit distance between the access's top N bytes and the doubleword's low end.
  function automatic logic [6:0] lane_shift(input logic [1:0] sz);
    return sz == 2'd0 ? 7'd56 : sz == 2'd1 ? 7'd48 : sz == 2'd2 ? 7'd32 : 7'd0;
  endfunction
endpackage

// File: rtl/mau_lane.sv
// mau_lane: big-endian load extraction/extension and sub-doubleword store merge.
module mau_lane
  import mau_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [63:0] wdata,
  input  logic [63:0] rdata,
  output logic [63:0] load_data,
  output logic [63:0] merged
);
  logic [6:0]  sh;
  logic [63:0] mask;
  logic [63:0] sext;
  always_comb begin
    sh        = lane_shift(funct3[1:0]);
    mask      = {64{1'b1}} << sh;
    sext      = $signed(rdata) >>> sh;
    load_data = funct3[2] ? rdata >> sh : sext;
    merged    = (wdata << sh) | (rdata & ~mask);
  end
endmodule

// File: rtl/memory_access_unit.sv
// memory_access_unit: load/store FSM in front of a big-endian 8-byte memory port.
// Define MEMORY_ACCESS_BOUNDS_CHECK_EN to reject addresses above MEM_BYTES-8.
module memory_access_unit
  import mau_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata
);
  state_e      state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] data_q, data_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        write_q, write_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [63:0] resp_rdata_q, resp_rdata_d;
  logic [63:0] load_data, merged;
  logic        accept, bad;

  mau_lane u_lane (
    .funct3   (funct3_q),
    .wdata    (data_q),
    .rdata    (mem_rdata),
    .load_data(load_data),
    .merged   (merged)
  );

  always_comb begin
    accept = req_valid & req_ready;
`ifdef MEMORY_ACCESS_BOUNDS_CHECK_EN
    bad = req_funct3 == F3_XX || (req_write && req_funct3[2]) || req_addr > 64'(MEM_BYTES - 8);
`else
    bad = req_funct3 == F3_XX || (req_write && req_funct3[2]);
`endif
    state_d      = state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    funct3_d     = funct3_q;
    write_d      = write_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    case (state_q)
      IDLE: if (accept) begin
        addr_d       = req_addr;
        data_d       = req_wdata;
        funct3_d     = req_funct3;
        write_d      = req_write;
        state_d      = bad ? DONE : !req_write ? LOAD : req_funct3 == F3_D ? WRITE : RMW_READ;
        resp_valid_d = bad;
        resp_err_d   = bad;
      end
      LOAD: begin
        state_d      = DONE;
        resp_valid_d = 1'b1;
        resp_rdata_d = write_q ? '0 : load_data;
      end
      RMW_READ: begin
        state_d = WRITE;
        data_d  = merged;
      end
      WRITE: begin
        state_d      = DONE;
        resp_valid_d = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      funct3_q     <= '0;
      write_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      funct3_q     <= funct3_d;
      write_q      <= write_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign req_ready  = state_q == IDLE && !reset;
  assign mem_read   = (state_q == LOAD || state_q == RMW_READ) && !reset;
  assign mem_write  = state_q == WRITE && !reset;
  assign mem_addr   = state_q == IDLE ? '0 : addr_q;
  assign mem_wdata  = state_q == WRITE ? data_q : '0;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
endmodule

// File: tb/tb_memory_access_unit.sv
// tb_memory_access_unit: randomized and directed checks of memory_access_unit against a byte-level model.
module tb_memory_access_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        mem_read, mem_write;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  dmem [0:4095];
  logic [7:0]  rmem [0:4095];
  int n_chk = 0;
  int n_err = 0;

  memory_access_unit #(.MEM_BYTES(2048)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always_comb begin
    mem_rdata = '0;
    for (int i = 0; i < 8; i++) mem_rdata[63-8*i -: 8] = dmem[12'(mem_addr + 64'(i))];
  end

  always @(posedge clk)
    if (mem_write) for (int i = 0; i < 8; i++) dmem[12'(mem_addr + 64'(i))] <= mem_wdata[63-8*i -: 8];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] dw(input bit from_ref, input logic [63:0] a);
    logic [63:0] v = '0;
    for (int i = 0; i < 8; i++) v = (v << 8) | 64'(from_ref ? rmem[12'(a + 64'(i))] : dmem[12'(a + 64'(i))]);
    return v;
  endfunction

  task automatic set_dw(input logic [63:0] a, input logic [63:0] v);
    for (int i = 0; i < 8; i++) begin
      dmem[12'(a + 64'(i))] = v[63-8*i -: 8];
      rmem[12'(a + 64'(i))] = v[63-8*i -: 8];
    end
  endtask

  // Reference: apply the request to rmem and predict response, latency and memory traffic.
  task automatic model(input bit w, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd,
                       output bit err, output logic [63:0] rd, output int lat, output bit reads);
    int n = 1 << f3[1:0];
    logic [63:0] v = '0;
    err = f3 == 3'd7 || (w && f3[2]);
`ifdef MEMORY_ACCESS_BOUNDS_CHECK_EN
    if (a > 64'd2040) err = 1;
`endif
    rd = '0;
    reads = !err && (!w || n < 8);
    if (err) lat = 1;
    else if (w) begin
      for (int i = 0; i < n; i++) rmem[12'(a + 64'(i))] = wd[8*(n-1-i) +: 8];
      lat = n == 8 ? 2 : 3;
    end else begin
      for (int i = 0; i < n; i++) v = (v << 8) | 64'(rmem[12'(a + 64'(i))]);
      if (!f3[2] && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8*n));
      rd = v;
      lat = 2;
    end
  endtask

  task automatic do_req(input bit w, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd);
    bit exp_err, exp_reads;
    logic [63:0] exp_rd, rd;
    int exp_lat, lat, reads, writes, g;
    bit err;
    model(w, f3, a, wd, exp_err, exp_rd, exp_lat, exp_reads);
    g = 0;
    while (!req_ready && g < 20) begin @(negedge clk); g++; end
    check("ready_wait", 64'(req_ready), 64'd1);
    req_valid = 1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 0;
    lat = 0; reads = 0; writes = 0; rd = '0; err = 0;
    for (int k = 1; k <= 6 && lat == 0; k++) begin
      @(negedge clk);
      reads += int'(mem_read);
      writes += int'(mem_write);
      if (k == 1 && !exp_err) check("busy_addr", mem_addr, a);
      if (resp_valid) begin lat = k; rd = resp_rdata; err = resp_err; end
    end
    check("latency", 64'(lat), 64'(exp_lat));
    check("resp_err", 64'(err), 64'(exp_err));
    check("resp_rdata", rd, exp_rd);
    check("writes", 64'(writes), (w && !exp_err) ? 64'd1 : 64'd0);
    check("reads", 64'(reads != 0), 64'(exp_reads));
    check("mem_dw", dw(0, a), dw(1, a));
    @(negedge clk);
    check("ready_after", 64'(req_ready), 64'd1);
    check("idle_addr", mem_addr, 64'd0);
  endtask

  task automatic reset_in_write(input logic [63:0] a, input logic [63:0] wd);
    int g = 0;
    while (!req_ready && g < 20) begin @(negedge clk); g++; end
    req_valid = 1; req_write = 1; req_funct3 = 3'b010; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 0;
    g = 0;
    do begin @(negedge clk); g++; end while (!mem_write && g < 6);
    check("reached_write", 64'(mem_write), 64'd1);
    reset = 1; #1;
    check("rst_no_write", 64'(mem_write), 64'd0);
    @(posedge clk); @(negedge clk);
    reset = 0; #1;
    check("ready_post_rst", 64'(req_ready), 64'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("no_resp_post_rst", 64'(resp_valid), 64'd0);
    end
    check("rst_mem_kept", dw(0, a), dw(1, a));
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      dmem[i] = 8'($urandom);
      rmem[i] = dmem[i];
    end
    set_dw(0, 64'h8);
    set_dw(8, 64'h6);
    set_dw(24, 64'h10);
    reset = 1;
    repeat (3) begin
      @(negedge clk);
      check("rst_ready", 64'(req_ready), 64'd0);
      check("rst_rw", 64'({mem_read, mem_write}), 64'd0);
    end
    check("rst_valid", 64'(resp_valid), 64'd0);
    check("rst_err", 64'(resp_err), 64'd0);
    check("rst_rdata", resp_rdata, 64'd0);
    check("rst_addr", mem_addr, 64'd0);
    reset = 0; #1;
    check("ready_on_release", 64'(req_ready), 64'd1);
    do_req(0, 3'b011, 0, 0);
    do_req(1, 3'b000, 24, 64'hFF);
    check("sb_merge", dw(0, 24), 64'hFF00000000000010);
    do_req(0, 3'b000, 24, 0);
    do_req(0, 3'b100, 24, 0);
    do_req(1, 3'b001, 8, 64'h1234);
    do_req(0, 3'b011, 8, 0);
    do_req(0, 3'b110, 8, 0);
    do_req(0, 3'b111, 16, 0);
    do_req(1, 3'b100, 16, 64'h55);
    do_req(1, 3'b011, 32, 64'h0123456789ABCDEF);
    do_req(0, 3'b010, 32, 0);
`ifdef MEMORY_ACCESS_BOUNDS_CHECK_EN
    do_req(0, 3'b011, 2041, 0);
    do_req(0, 3'b011, 2040, 0);
`endif
    reset_in_write(48, 64'hDEADBEEF);
    for (int t = 0; t < 300; t++)
      do_req(1'($urandom), 3'($urandom), 64'($urandom_range(0, 2047)), {$urandom, $urandom});
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
